// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte FIFO feeding a one-frame-at-a-time transmit sequencer.
// The sequencer issues a single-cycle tx_start, holds tx_data for the whole frame, waits for
// tx_done, and inserts one low gap cycle before the next start.
// Optional build macro UART_TX_FIFO_CRLF_EN: a queued 8'h0A goes out as 8'h0D then 8'h0A.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          idle,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  input  logic          tx_done
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    head;
  logic          push, pop;
`ifdef UART_TX_FIFO_CRLF_EN
  logic          cr_q, cr_d;
  logic          send_cr;
`endif

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign idle     = empty && (state_q == StIdle);
  assign tx_start = (state_q == StStart);
  assign tx_data  = tx_data_q;

  assign head = mem[rd_ptr_q];
  assign push = wr_en && !full;

`ifdef UART_TX_FIFO_CRLF_EN
  // A line feed at the head is preceded by a carriage return unless one was already sent.
  assign send_cr = (head == 8'h0A) && !cr_q;
`endif

  // Sequencer next state, head pop and transmit-byte selection.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_d      = cr_q;
`endif
    case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) begin
          state_d   = StStart;
`ifdef UART_TX_FIFO_CRLF_EN
          tx_data_d = send_cr ? 8'h0D : head;
`else
          tx_data_d = head;
`endif
        end
      end
      StStart: begin
        state_d = StWait;
`ifdef UART_TX_FIFO_CRLF_EN
        // Head is unchanged since entry, so send_cr still tells which byte went out.
        if (send_cr) begin
          cr_d = 1'b1;
        end else begin
          pop  = 1'b1;
          cr_d = 1'b0;
        end
`else
        pop = 1'b1;
`endif
      end
      StWait: begin
        if (tx_done) state_d = StGap;
      end
      StGap: begin
        // Keeps tx_start low for a cycle so the transmitter re-arms its edge detector.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy counter: simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // FIFO storage; contents need no reset because pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers, level, sticky overflow (set beats clear) and sequencer state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tx_data_q <= tx_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && full) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FIFO_CRLF_EN
  // Remembers that the carriage return for the head line feed has been sent.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cr_q <= 1'b0;
    end else begin
      cr_q <= cr_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: reference queue model plus a behavioural transmitter.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          resetn, wr_en, ovf_clr, tx_busy, tx_done;
  logic [7:0]    wr_data;
  logic          full, empty, overflow, idle, tx_start;
  logic [AW:0]   level;
  logic [7:0]    tx_data;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .idle(idle),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: bytes held in the FIFO, sticky overflow, CR flag.
  logic [7:0] mq[$];
  logic       ovf_m = 1'b0;
  logic       cr_m = 1'b0;
  logic       pop_pend = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         n_acc = 0;

  // Transmitter model and observation logs.
  logic       auto_tx = 1'b0;
  logic       rnd_frames = 1'b0;
  int         frame_len = 8;
  int         tx_cnt = 0;
  int         cyc = 0;
  logic [7:0] starts_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    int         exp_level;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: update the model from the inputs, take the edge, check, run the transmitter.
  task automatic step();
    logic       full_m;
    logic [7:0] exp_b;
    full_m = (mq.size() == DEPTH);
    if (!resetn) begin
      mq.delete();
      ovf_m     = 1'b0;
      cr_m      = 1'b0;
      last_data = 8'h00;
    end else begin
      if (pop_pend) void'(mq.pop_front());
      if (wr_en && !full_m) begin
        mq.push_back(wr_data);
        n_acc++;
      end
      if (wr_en && full_m) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
    end
    pop_pend = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    if (tx_start) begin
      chk("start_one_cycle", 32'(prev_start), 32'd0);
      if (mq.size() == 0) begin
        chk("start_on_empty", 32'(mq.size()), 32'd1);
        exp_b = 8'h00;
      end else begin
`ifdef UART_TX_FIFO_CRLF_EN
        if (mq[0] == 8'h0A && !cr_m) begin
          exp_b = 8'h0D;
          cr_m  = 1'b1;
        end else begin
          exp_b    = mq[0];
          cr_m     = 1'b0;
          pop_pend = 1'b1;
        end
`else
        exp_b    = mq[0];
        pop_pend = 1'b1;
`endif
      end
      chk("tx_data_at_start", 32'(tx_data), 32'(exp_b));
      last_data = exp_b;
      starts_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
    end else begin
      chk("tx_data_stable", 32'(tx_data), 32'(last_data));
    end
    prev_start = tx_start;
    if (auto_tx) begin
      tx_done = 1'b0;
      if (tx_busy) begin
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 1'b0;
          done_cyc_q.push_back(cyc);
        end else begin
          tx_cnt--;
        end
      end
      if (tx_start) begin
        tx_busy = 1'b1;
        tx_cnt  = rnd_frames ? int'($urandom_range(2, 12)) : frame_len;
      end
    end
  endtask

  task automatic drain(input int limit);
    int i;
    i = 0;
    while (!(idle && !tx_busy && !tx_done) && i < limit) begin
      step();
      i++;
    end
    chk("drain_done", 32'(idle && !tx_busy), 32'd1);
  endtask

  task automatic clear_logs();
    starts_q.delete();
    start_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, 8'(8'h10 + i), 1'b0, i + 1, (i == 15), 1'b0};
    vecs[16] = '{1'b1, 8'hEE, 1'b0, 16, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 8'hEF, 1'b1, 16, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};

    resetn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0;
    step();
    step();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    resetn = 1'b1;
    auto_tx = 1'b1;

    // Single byte: start two edges after the write, 1000-cycle frame, idle after the gap.
    frame_len = 1000;
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    chk("k_level", 32'(level), 32'd1);
    chk("k_empty", 32'(empty), 32'd0);
    chk("k_start", 32'(tx_start), 32'd0);
    wr_en = 1'b0;
    step();
    chk("k1_start", 32'(tx_start), 32'd1);
    chk("k1_data", 32'(tx_data), 32'h55);
    step();
    chk("k2_start", 32'(tx_start), 32'd0);
    chk("k2_level", 32'(level), 32'd0);
    n = 0;
    while (!tx_done && n < 1100) begin
      step();
      n++;
    end
    chk("k_done_seen", 32'(tx_done), 32'd1);
    chk("k_idle_wait", 32'(idle), 32'd0);
    step();
    chk("k_idle_gap", 32'(idle), 32'd0);
    step();
    chk("k_idle_after", 32'(idle), 32'd1);

    // Burst of four: order preserved, each start exactly 3 cycles after the prior done.
    frame_len = 8;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h41 + i);
      step();
    end
    wr_en = 1'b0;
    drain(200);
    chk("burst_count", 32'(starts_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < starts_q.size(); i++) begin
      chk("burst_data", 32'(starts_q[i]), 32'(8'h41 + i));
      if (i > 0 && i <= done_cyc_q.size())
        chk("burst_gap", 32'(start_cyc_q[i] - done_cyc_q[i-1]), 32'd3);
    end

    // Table vectors: fill past DEPTH with the transmitter held busy.
    auto_tx = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].data; ovf_clr = vecs[i].clr;
      step();
      chk("tbl_level", 32'(level), 32'(vecs[i].exp_level));
      chk("tbl_full", 32'(full), 32'(vecs[i].exp_full));
      chk("tbl_overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
      chk("tbl_no_start", 32'(tx_start), 32'd0);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    clear_logs();
    tx_busy = 1'b0; auto_tx = 1'b1; frame_len = 3;
    drain(400);
    chk("tbl_sent_count", 32'(starts_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < starts_q.size(); i++)
      chk("tbl_sent_data", 32'(starts_q[i]), 32'(8'h10 + i));

    // Write coinciding with the START pop at level 3 leaves level at 3.
    auto_tx = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      step();
    end
    wr_en = 1'b0; tx_busy = 1'b0; auto_tx = 1'b1;
    step();
    chk("sim_start", 32'(tx_start), 32'd1);
    chk("sim_level_pre", 32'(level), 32'd3);
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    chk("sim_level_post", 32'(level), 32'd3);
    wr_en = 1'b0;
    drain(200);

    // Reset during WAIT with two bytes queued and the transmitter still busy.
    frame_len = 30;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA1 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("rw_level_pre", 32'(level), 32'd2);
    chk("rw_busy", 32'(tx_busy), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rw_level_post", 32'(level), 32'd0);
    chk("rw_idle_post", 32'(idle), 32'd1);
    chk("rw_tx_data_post", 32'(tx_data), 32'd0);
    wr_en = 1'b1; wr_data = 8'hB5;
    step();
    wr_en = 1'b0;
    clear_logs();
    n = 0;
    while (tx_busy && n < 100) begin
      step();
      n++;
    end
    chk("rw_busy_fell", 32'(tx_busy), 32'd0);
    chk("rw_no_start_while_busy", 32'(starts_q.size()), 32'd0);
    drain(200);
    chk("rw_resume_count", 32'(starts_q.size()), 32'd1);
    if (starts_q.size() > 0) chk("rw_resume_data", 32'(starts_q[0]), 32'hB5);

    // Line feed handling.
    clear_logs();
    wr_en = 1'b1; wr_data = 8'h0A;
    step();
    wr_en = 1'b0;
    drain(200);
`ifdef UART_TX_FIFO_CRLF_EN
    chk("lf_count", 32'(starts_q.size()), 32'd2);
    if (starts_q.size() == 2) begin
      chk("lf_first", 32'(starts_q[0]), 32'h0D);
      chk("lf_second", 32'(starts_q[1]), 32'h0A);
    end
`else
    chk("lf_count", 32'(starts_q.size()), 32'd1);
    if (starts_q.size() > 0) chk("lf_only", 32'(starts_q[0]), 32'h0A);
`endif

    // Randomized traffic against the reference model.
    clear_logs();
    rnd_frames = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 600; i++) begin
      wr_en   = (i < 300) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
      wr_data = 8'($urandom);
      if (wr_data == 8'h0A) wr_data = 8'h0B;
      ovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    drain(2000);
    chk("rand_sent_count", 32'(starts_q.size()), 32'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
